// File: rtl/fi_fd_join.sv
// Joins the insertion (f_i) and deletion (f_d) MULT_ADD result streams.
// Each side is buffered in an in-order FIFO; a pair leaves when both heads exist.

module fi_fd_join_fifo #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_valid,
  input  logic [63:0]      push_result,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output logic [63:0]      head_result,
  output logic [TAG_W-1:0] head_tag,
  output logic             not_empty,
  output logic             stall,
  output logic             drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_SKID = (AW+1)'(DEPTH - 1);

  logic [63:0]      mem_result [DEPTH];
  logic [TAG_W-1:0] mem_tag    [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, push;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign full        = (count == CNT_FULL);
  assign push        = push_valid && (!full || pop);
  assign drop        = push_valid && full && !pop;
  assign not_empty   = (count != '0);
  assign stall       = (count >= CNT_SKID);
  assign head_result = mem_result[rd_ptr];
  assign head_tag    = mem_tag[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the count gates every read, so
  // stale contents are never observed and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_result[wr_ptr] <= push_result;
      mem_tag[wr_ptr]    <= push_tag;
    end
  end
endmodule

module fi_fd_join #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      i_result,
  input  logic             i_done,
  input  logic [TAG_W-1:0] i_tag,
  input  logic [63:0]      d_result,
  input  logic             d_done,
  input  logic [TAG_W-1:0] d_tag,
  input  logic             global_stall,
  output logic [63:0]      f_i,
  output logic [63:0]      f_d,
  output logic [TAG_W-1:0] tag_out,
  output logic             done,
  output logic             stall_i,
  output logic             stall_d,
  output logic             tag_error,
  output logic             overflow
);
  logic [63:0]      head_i, head_d;
  logic [TAG_W-1:0] head_tag_i, head_tag_d;
  logic             ne_i, ne_d, drop_i, drop_d, pop;

  assign pop = ne_i && ne_d && !global_stall;

  fi_fd_join_fifo #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_fifo_i (
    .clk(clk), .reset(reset), .push_valid(i_done), .push_result(i_result),
    .push_tag(i_tag), .pop(pop), .head_result(head_i), .head_tag(head_tag_i),
    .not_empty(ne_i), .stall(stall_i), .drop(drop_i)
  );

  fi_fd_join_fifo #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_fifo_d (
    .clk(clk), .reset(reset), .push_valid(d_done), .push_result(d_result),
    .push_tag(d_tag), .pop(pop), .head_result(head_d), .head_tag(head_tag_d),
    .not_empty(ne_d), .stall(stall_d), .drop(drop_d)
  );

  // NOTE: registered outputs use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_i       <= '0;
      f_d       <= '0;
      tag_out   <= '0;
      done      <= 1'b0;
      tag_error <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (!global_stall) begin
        done <= pop;
        if (pop) begin
          f_i     <= head_i;
          f_d     <= head_d;
          tag_out <= head_tag_i;
        end
      end
      if (pop && (head_tag_i != head_tag_d)) tag_error <= 1'b1;
      if (drop_i || drop_d)                  overflow  <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fi_fd_join.sv
// Directed self-checking bench for fi_fd_join (DEPTH=4, 8-bit tags).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.

module tb_fi_fd_join;
  localparam int DEPTH = 4;
  localparam int TAG_W = 8;

  logic             clk = 1'b0;
  logic             reset, i_done, d_done, global_stall;
  logic [63:0]      i_result, d_result, f_i, f_d;
  logic [TAG_W-1:0] i_tag, d_tag, tag_out;
  logic             done, stall_i, stall_d, tag_error, overflow;

  int n_cmp = 0;
  int n_bad = 0;

  fi_fd_join #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .i_result(i_result), .i_done(i_done), .i_tag(i_tag),
    .d_result(d_result), .d_done(d_done), .d_tag(d_tag), .global_stall(global_stall),
    .f_i(f_i), .f_d(f_d), .tag_out(tag_out), .done(done), .stall_i(stall_i),
    .stall_d(stall_d), .tag_error(tag_error), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; i_done = 1'b0; d_done = 1'b0; global_stall = 1'b0;
  endtask

  task automatic drive_pair(input logic [63:0] vi, input logic [63:0] vd,
                            input logic [7:0] ti, input logic [7:0] td);
    i_done = 1'b1; i_result = vi; i_tag = ti;
    d_done = 1'b1; d_result = vd; d_tag = td;
  endtask

  task automatic test_reset();
    reset = 1'b1; drive_pair(64'h1, 64'h2, 8'h01, 8'h01);
    tick();
    idle();
    n_cmp++;
    if ({done, stall_i, stall_d, tag_error, overflow} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 00000", {done, stall_i, stall_d, tag_error, overflow});
    end
    n_cmp++;
    if ({f_i, f_d, tag_out} !== {64'h0, 64'h0, 8'h00}) begin
      n_bad++; $display("FAIL reset_data: got %h %h %h expected zeros", f_i, f_d, tag_out);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if (done !== 1'b0) begin
        n_bad++; $display("FAIL reset_ignores_done: cycle %0d got done=%b expected 0", k, done);
      end
    end
  endtask

  task automatic test_same_cycle();
    drive_pair(64'h3FF0000000000000, 64'h4000000000000000, 8'h11, 8'h11);
    tick();
    idle();
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL same_cycle_T1: got done=%b expected 0", done);
    end
    tick();
    n_cmp++;
    if ({done, f_i, f_d, tag_out, tag_error} !== {1'b1, 64'h3FF0000000000000, 64'h4000000000000000, 8'h11, 1'b0}) begin
      n_bad++; $display("FAIL same_cycle_T2: got %b %h %h %h %b expected 1 3ff0000000000000 4000000000000000 11 0",
                        done, f_i, f_d, tag_out, tag_error);
    end
    tick();
    n_cmp++;
    if ({done, f_i, tag_out} !== {1'b0, 64'h3FF0000000000000, 8'h11}) begin
      n_bad++; $display("FAIL same_cycle_hold: got %b %h %h expected 0 3ff0000000000000 11", done, f_i, tag_out);
    end
  endtask

  task automatic test_skew();
    i_result = 64'hA1; i_tag = 8'h22; d_result = 64'hD1; d_tag = 8'h22;
    for (int c = 1; c <= 6; c++) begin
      i_done = (c - 1 == 0);
      d_done = (c - 1 == 3);
      tick();
      i_done = 1'b0; d_done = 1'b0;
      n_cmp++;
      if (done !== (c == 5)) begin
        n_bad++; $display("FAIL skew_done: cycle T+%0d got %b expected %b", c, done, (c == 5));
      end
      if (c == 5) begin
        n_cmp++;
        if ({f_i, f_d, tag_out} !== {64'hA1, 64'hD1, 8'h22}) begin
          n_bad++; $display("FAIL skew_data: got %h %h %h expected a1 d1 22", f_i, f_d, tag_out);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n, idx;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive_pair(64'h1000 + 64'(c), 64'h2000 + 64'(c), 8'h30 + 8'(c), 8'h30 + 8'(c));
      else idle();
      tick();
      n = c + 1;
      n_cmp++;
      if (done !== (n >= 2 && n <= 5)) begin
        n_bad++; $display("FAIL b2b_done: cycle %0d got %b expected %b", n, done, (n >= 2 && n <= 5));
      end
      if (n >= 2 && n <= 5) begin
        idx = n - 2;
        n_cmp++;
        if ({f_i, f_d, tag_out, stall_i, stall_d} !== {64'h1000 + 64'(idx), 64'h2000 + 64'(idx), 8'h30 + 8'(idx), 2'b00}) begin
          n_bad++; $display("FAIL b2b_data: cycle %0d got %h %h %h %b%b expected pair %0d, no stall",
                            n, f_i, f_d, tag_out, stall_i, stall_d, idx);
        end
      end
    end
    idle();
  endtask

  task automatic test_stall_hold();
    drive_pair(64'h5000, 64'h6000, 8'h40, 8'h40);
    tick();
    drive_pair(64'h5001, 64'h6001, 8'h41, 8'h41);
    tick();
    idle();
    n_cmp++;
    if ({done, f_i, f_d, tag_out} !== {1'b1, 64'h5000, 64'h6000, 8'h40}) begin
      n_bad++; $display("FAIL stall_first: got %b %h %h %h expected 1 5000 6000 40", done, f_i, f_d, tag_out);
    end
    global_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if ({done, f_i, f_d, tag_out} !== {1'b1, 64'h5000, 64'h6000, 8'h40}) begin
        n_bad++; $display("FAIL stall_hold: cycle %0d got %b %h %h %h expected 1 5000 6000 40", k, done, f_i, f_d, tag_out);
      end
    end
    global_stall = 1'b0;
    tick();
    n_cmp++;
    if ({done, f_i, f_d, tag_out} !== {1'b1, 64'h5001, 64'h6001, 8'h41}) begin
      n_bad++; $display("FAIL stall_release: got %b %h %h %h expected 1 5001 6001 41", done, f_i, f_d, tag_out);
    end
    tick();
    n_cmp++;
    if ({done, f_i} !== {1'b0, 64'h5001}) begin
      n_bad++; $display("FAIL stall_after: got %b %h expected 0 5001", done, f_i);
    end
  endtask

  task automatic test_tag_mismatch();
    drive_pair(64'h7000, 64'h8000, 8'h55, 8'h56);
    tick();
    idle();
    tick();
    n_cmp++;
    if ({done, f_i, f_d, tag_out, tag_error} !== {1'b1, 64'h7000, 64'h8000, 8'h55, 1'b1}) begin
      n_bad++; $display("FAIL mismatch_emit: got %b %h %h %h %b expected 1 7000 8000 55 1",
                        done, f_i, f_d, tag_out, tag_error);
    end
    drive_pair(64'h7001, 64'h8001, 8'h60, 8'h60);
    tick();
    idle();
    tick();
    n_cmp++;
    if ({done, tag_out, tag_error} !== {1'b1, 8'h60, 1'b1}) begin
      n_bad++; $display("FAIL mismatch_sticky: got %b %h %b expected 1 60 1", done, tag_out, tag_error);
    end
    tick();
    tick();
    n_cmp++;
    if (tag_error !== 1'b1) begin
      n_bad++; $display("FAIL mismatch_sticky_idle: got %b expected 1", tag_error);
    end
  endtask

  task automatic test_fill_overflow();
    int n, idx;
    reset = 1'b1;
    tick();
    idle();
    n_cmp++;
    if ({tag_error, overflow} !== 2'b00) begin
      n_bad++; $display("FAIL fill_sticky_cleared: got %b expected 00", {tag_error, overflow});
    end
    for (int k = 0; k < 5; k++) begin
      i_done = 1'b1; i_result = 64'h9000 + 64'(k); i_tag = 8'h70 + 8'(k);
      tick();
      n_cmp++;
      if ({stall_i, overflow, done} !== {(k >= 2), (k == 4), 1'b0}) begin
        n_bad++; $display("FAIL fill_push: push %0d got stall_i=%b overflow=%b done=%b expected %b %b 0",
                          k + 1, stall_i, overflow, done, (k >= 2), (k == 4));
      end
    end
    idle();
    for (int c = 0; c < 8; c++) begin
      d_done = (c < 4); d_result = 64'hA000 + 64'(c); d_tag = 8'h70 + 8'(c);
      tick();
      d_done = 1'b0;
      n = c + 1;
      n_cmp++;
      if (done !== (n >= 2 && n <= 5)) begin
        n_bad++; $display("FAIL fill_drain_done: cycle %0d got %b expected %b", n, done, (n >= 2 && n <= 5));
      end
      if (n >= 2 && n <= 5) begin
        idx = n - 2;
        n_cmp++;
        if ({f_i, f_d, tag_out, tag_error} !== {64'h9000 + 64'(idx), 64'hA000 + 64'(idx), 8'h70 + 8'(idx), 1'b0}) begin
          n_bad++; $display("FAIL fill_drain_data: cycle %0d got %h %h %h %b expected entry %0d",
                            n, f_i, f_d, tag_out, tag_error, idx);
        end
      end
    end
    n_cmp++;
    if ({stall_i, stall_d, overflow} !== 3'b001) begin
      n_bad++; $display("FAIL fill_after: got %b expected 001", {stall_i, stall_d, overflow});
    end
    // A further D entry must find the I side empty: the dropped 5th push is gone.
    d_done = 1'b1; d_result = 64'hA004; d_tag = 8'h74;
    tick();
    idle();
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL fill_dropped: got done=%b expected 0", done);
    end
  endtask

  task automatic test_reset_midstream();
    global_stall = 1'b1;
    drive_pair(64'hE000, 64'hF000, 8'h80, 8'h80);
    tick();
    drive_pair(64'hE001, 64'hF001, 8'h81, 8'h81);
    tick();
    reset = 1'b1; global_stall = 1'b0;
    drive_pair(64'hEEEE, 64'hFFFF, 8'h8F, 8'h8F);
    tick();
    idle();
    n_cmp++;
    if ({done, f_i, f_d, tag_out, stall_i, stall_d, tag_error, overflow} !== {1'b0, 64'h0, 64'h0, 8'h00, 4'b0000}) begin
      n_bad++; $display("FAIL midreset_outputs: got %b %h %h %h %b expected all zero",
                        done, f_i, f_d, tag_out, {stall_i, stall_d, tag_error, overflow});
    end
    drive_pair(64'hB000, 64'hC000, 8'h90, 8'h90);
    tick();
    idle();
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL midreset_T1: got done=%b expected 0", done);
    end
    tick();
    n_cmp++;
    if ({done, f_i, f_d, tag_out} !== {1'b1, 64'hB000, 64'hC000, 8'h90}) begin
      n_bad++; $display("FAIL midreset_new_pair: got %b %h %h %h expected 1 b000 c000 90", done, f_i, f_d, tag_out);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if ({done, f_i} !== {1'b0, 64'hB000}) begin
        n_bad++; $display("FAIL midreset_no_stale: cycle %0d got %b %h expected 0 b000", k, done, f_i);
      end
    end
  endtask

  initial begin
    idle();
    i_result = '0; d_result = '0; i_tag = '0; d_tag = '0;
    test_reset();
    test_same_cycle();
    test_skew();
    test_back_to_back();
    test_stall_hold();
    test_tag_mismatch();
    test_fill_overflow();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fi_fd_join.md
FI_FD_JOIN -- requirements
Module: fi_fd_join

Interface
REQ-001 Parameter DEPTH, default 4, meaning per-side FIFO entries (power of two, >=2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 i_result  input  64  f_i double from insertion MULT_ADD result.
REQ-005 i_done  input  1  i_result/i_tag valid this cycle.
REQ-006 i_tag  input  TAG  tag accompanying i_result.
REQ-007 d_result  input  64  f_d double from deletion MULT_ADD result.
REQ-008 d_done  input  1  d_result/d_tag valid this cycle.
REQ-009 d_tag  input  TAG  tag accompanying d_result.
REQ-010 global_stall  input  1  downstream cannot accept; hold outputs.
REQ-011 f_i  output  64  joined insertion value.
REQ-012 f_d  output  64  joined deletion value.
REQ-013 tag_out  output  TAG  tag of joined pair (insertion-side tag).
REQ-014 done  output  1  f_i/f_d/tag_out valid.
REQ-015 stall_i  output  1  back-pressure to insertion MULT_ADD (drives its global_stall).
REQ-016 stall_d  output  1  back-pressure to deletion MULT_ADD.
REQ-017 tag_error  output  1  sticky: a popped pair had i_tag != d_tag.
REQ-018 overflow  output  1  sticky: a done arrived while its FIFO was full and not popping.

Function
REQ-019 Two independent in-order FIFOs (I-side, D-side), DEPTH entries each, storing {64-bit result, TAG}; counts 0..DEPTH.
REQ-020 Push I when i_done=1 and (count_i<DEPTH or pop this cycle); same rule for D.
REQ-021 Pop = both FIFOs non-empty AND global_stall=0; pops both sides in the same cycle.
REQ-022 On pop, next cycle: f_i/f_d/tag_out = FIFO heads, done=1.
REQ-023 No pop and global_stall=0: next cycle done=0; f_i/f_d/tag_out hold prior values.
REQ-024 global_stall=1: done, f_i, f_d, tag_out all hold; no pop.
REQ-025 Latency: both done at cycle T into empty FIFOs, global_stall=0 -> done=1 in cycle T+2.
REQ-026 Throughput: one pair per cycle sustained when both sides push every cycle, no stall.
REQ-027 Simultaneous push and pop on a side: count unchanged; legal at count=DEPTH.
REQ-028 stall_i = (count_i >= DEPTH-1); stall_d likewise (one-slot skid for in-flight done).
REQ-029 Push when count=DEPTH and no pop: data dropped, FIFO unchanged, overflow set to 1.
REQ-030 Tag check on pop: whole-TAG inequality sets tag_error=1; the pair is still emitted.
REQ-031 Ordering: pairs emitted strictly in arrival order per side; no reordering by tag.
REQ-032 Pointers wrap modulo DEPTH; count, not pointer equality, determines full/empty.
REQ-033 Sticky flags clear only on reset.

Reset
REQ-034 reset=1 at a clock edge: counts, pointers = 0; done, stall_i, stall_d, tag_error, overflow = 0; f_i, f_d = 64'h0; tag_out = all-zero TAG.
REQ-035 Reset mid-operation discards all queued entries; i_done/d_done in the reset cycle are ignored.
REQ-036 First push accepted on the first edge with reset=0.

Verification
REQ-037 Same-cycle join: i_done=d_done=1 at T, i_result=64'h3FF0000000000000, d_result=64'h4000000000000000, tags equal -> done=1 at T+2 with those values, tag_error=0.
REQ-038 Skew: i_done at T, d_done at T+3 (equal tags) -> done=1 exactly at T+5, once; done=0 at T+2..T+4.
REQ-039 Fill: DEPTH=4, 3 I-pushes, no D -> stall_i=1 after 3rd push; 4th push accepted; 5th push -> overflow=1, count_i stays 4.
REQ-040 Stall hold: pair valid (done=1), global_stall=1 for 3 cycles -> outputs and done unchanged; next pair emitted the cycle after release.
REQ-041 Mismatch: equal-time pushes with i_tag != d_tag -> pair emitted, tag_error=1 and stays 1 until reset.
REQ-042 Reset mid-stream: 2 entries queued each side, reset 1 cycle -> all outputs 0, subsequent new pair emitted with 2-cycle latency, none of the stale pairs appear.
